// File: rtl/byte_mem_pkg.sv
// byte_mem_pkg: shared state type, byte width and write/read overlap helper for byte_mem_bank
package byte_mem_pkg;
  typedef enum logic {ST_INIT, ST_RUN} state_t;
  localparam int BYTE_W = 8;
  // True when byte address addr_r falls on an enabled byte of the nb-byte write word at addr_w
  function automatic logic be_mask_hit(input logic [31:0] addr_w, input logic [7:0] be,
                                       input logic [31:0] addr_r, input int aw, input int nb);
    logic [31:0] k;
    k = (addr_r - addr_w) & ((32'd1 << aw) - 32'd1);
    return (k < 32'(nb)) && be[3'(nb - 1 - int'(k))];
  endfunction
endpackage

// File: rtl/byte_mem_rd_pipe.sv
// byte_mem_rd_pipe: LAT-deep valid+data shift register; each stage holds its data between valid beats
module byte_mem_rd_pipe #(
  parameter int LAT = 1,
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);
  logic [LAT-1:0] vld, v_nxt;
  logic [LAT-1:0][W-1:0] dat, d_nxt;
  assign v_nxt = LAT'({vld, in_valid});
  assign d_nxt = (LAT*W)'({dat, in_data});
  always_ff @(posedge clk)
    if (rst) begin
      vld <= '0;
      dat <= '0;
    end else begin
      vld <= v_nxt;
      for (int s = 0; s < LAT; s++)
        if (v_nxt[s]) dat[s] <= d_nxt[s];
    end
  assign out_valid = vld[LAT-1];
  assign out_data = dat[LAT-1];
endmodule

// File: rtl/byte_mem_bank.sv
// byte_mem_bank: big-endian byte-addressed data memory with post-reset zero-fill and pipelined reads.
// Define MEM_WR_FWD_EN for write-first forwarding into same-cycle reads; default is read-first.
module byte_mem_bank
  import byte_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_BYTES = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_req,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [BYTE_W*DATA_BYTES-1:0] wr_data,
  input  logic [DATA_BYTES-1:0]        wr_be,
  output logic                         wr_done,
  input  logic                         rd_req,
  input  logic [ADDR_WIDTH-1:0]        rd_addr,
  output logic [BYTE_W*DATA_BYTES-1:0] rd_data,
  output logic                         rd_done,
  output logic                         init_busy
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int DW = BYTE_W * DATA_BYTES;
  logic [BYTE_W-1:0] mem [DEPTH];
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] fill;
  logic run, wr_acc, rd_acc, last_beat;
  logic [DW-1:0] rd_word;
  assign run = state == ST_RUN;
  assign init_busy = !run;
  assign wr_acc = wr_req && run;
  assign rd_acc = rd_req && run;
  assign last_beat = 32'(fill) + 32'(DATA_BYTES) >= 32'(DEPTH);
  always_comb state_n = (state == ST_INIT && last_beat) ? ST_RUN : state;
  always_ff @(posedge clk) begin
    state <= rst ? ST_INIT : state_n;
    fill <= (rst || run) ? '0 : fill + ADDR_WIDTH'(DATA_BYTES);
    wr_done <= !rst && wr_acc;
  end
  always_ff @(posedge clk)
    if (!rst)
      for (int i = 0; i < DATA_BYTES; i++)
        if (!run) mem[fill + ADDR_WIDTH'(i)] <= '0;
        else if (wr_acc && wr_be[DATA_BYTES-1-i])
          mem[wr_addr + ADDR_WIDTH'(i)] <= wr_data[DW-1-BYTE_W*i -: BYTE_W];
  // Read taps are combinational off the array, so without forwarding they see pre-write contents
  always_comb begin
`ifdef MEM_WR_FWD_EN
    logic [ADDR_WIDTH-1:0] k;
`endif
    rd_word = '0;
    for (int j = 0; j < DATA_BYTES; j++) begin
      rd_word[DW-1-BYTE_W*j -: BYTE_W] = mem[rd_addr + ADDR_WIDTH'(j)];
`ifdef MEM_WR_FWD_EN
      k = rd_addr + ADDR_WIDTH'(j) - wr_addr;
      if (wr_acc && be_mask_hit(32'(wr_addr), 8'(wr_be), 32'(rd_addr + ADDR_WIDTH'(j)), ADDR_WIDTH, DATA_BYTES))
        rd_word[DW-1-BYTE_W*j -: BYTE_W] = wr_data[DW-1-BYTE_W*int'(k) -: BYTE_W];
`endif
    end
  end
  byte_mem_rd_pipe #(.LAT(RD_LATENCY), .W(DW)) u_pipe (
    .clk(clk),
    .rst(rst),
    .in_valid(rd_acc),
    .in_data(rd_word),
    .out_valid(rd_done),
    .out_data(rd_data)
  );
endmodule
